ks_adder_pipe: RTL and testbench

//  Parametrised, fully pipelined Kogge-Stone adder/subtractor with valid/ready handshake.

---
 rtl/ks_adder_pipe.sv | 114 +++++++++++
 tb/tb_ks_adder_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: one pre-processing stage, log2(WIDTH) prefix
// stages and a registered post-processing stage, all advancing together under backpressure.
module ks_adder_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             advance_s;
  logic             c0_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] p0_s;
  logic [WIDTH-1:0] g0_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;

  // Stage k of these arrays holds the state after k prefix levels have been applied.
  logic [LEVELS:0]  vld_r;
  logic [LEVELS:0]  c0_r;
  logic [WIDTH-1:0] pb_r [0:LEVELS];
  logic [WIDTH-1:0] g_r  [0:LEVELS];
  logic [WIDTH-1:0] gp_r [0:LEVELS];

  logic             out_valid_r;
  logic [WIDTH-1:0] out_sum_r;
  logic             out_cout_r;
  logic             out_ovf_r;

  // One Kogge-Stone level at distance d; bits below d have no partner and pass through.
  function automatic logic [2*WIDTH-1:0] prefix_level(
    input logic [WIDTH-1:0] g,
    input logic [WIDTH-1:0] p,
    input int unsigned      d
  );
    logic [WIDTH-1:0] low_mask;
    low_mask = ~({WIDTH{1'b1}} << d);
    return {g | (p & (g << d)), p & ((p << d) | low_mask)};
  endfunction

  assign advance_s = ~out_valid_r | out_ready;
  assign in_ready  = advance_s;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_cout  = out_cout_r;
  assign out_ovf   = out_ovf_r;
  assign busy      = (|vld_r) | out_valid_r;

  // Operand conditioning and bitwise generate/propagate; carry-in folds into bit 0.
  always_comb begin
    b_eff_s = in_sub ? ~in_b : in_b;
    c0_s    = in_sub ^ in_cin;
    p0_s    = in_a ^ b_eff_s;
    g0_s    = (in_a & b_eff_s) | {{(WIDTH-1){1'b0}}, p0_s[0] & c0_s};
  end

  // Post-processing from the final prefix stage: G[i] is the carry into bit i+1.
  always_comb begin
    sum_s  = pb_r[LEVELS] ^ {g_r[LEVELS][WIDTH-2:0], c0_r[LEVELS]};
    cout_s = g_r[LEVELS][WIDTH-1];
    ovf_s  = g_r[LEVELS][WIDTH-1] ^ g_r[LEVELS][WIDTH-2];
  end

  // Whole pipeline shifts one stage on advance and holds (bubbles included) otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r       <= {(LEVELS+1){1'b0}};
      c0_r        <= {(LEVELS+1){1'b0}};
      for (int k = 0; k <= LEVELS; k++) begin
        pb_r[k] <= {WIDTH{1'b0}};
        g_r[k]  <= {WIDTH{1'b0}};
        gp_r[k] <= {WIDTH{1'b0}};
      end
      out_valid_r <= 1'b0;
      out_sum_r   <= {WIDTH{1'b0}};
      out_cout_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else if (advance_s) begin
      vld_r[0] <= in_valid;
      c0_r[0]  <= c0_s;
      pb_r[0]  <= p0_s;
      g_r[0]   <= g0_s;
      gp_r[0]  <= p0_s;
      for (int k = 1; k <= LEVELS; k++) begin
        vld_r[k]            <= vld_r[k-1];
        c0_r[k]             <= c0_r[k-1];
        pb_r[k]             <= pb_r[k-1];
        {g_r[k], gp_r[k]}   <= prefix_level(g_r[k-1], gp_r[k-1], 32'd1 << (k-1));
      end
      out_valid_r <= vld_r[LEVELS];
      out_sum_r   <= sum_s;
      out_cout_r  <= cout_s;
      out_ovf_r   <= ovf_s;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Checks ks_adder_pipe at WIDTH=8 (full handshake) and WIDTH=13/32 (free-running) against
// an arithmetic reference model using scoreboards of expected results and accept cycles.
module tb_ks_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        cin;
  logic        sub;
  logic        out_ready8;
  logic        rdy_rand;
  logic [33:0] exp_cur;

  logic        ir8, ov8, cout8, ovf8, busy8;
  logic [7:0]  sum8;
  logic        ir13, ov13, cout13, ovf13, busy13;
  logic [12:0] sum13;
  logic        ir32, ov32, cout32, ovf32, busy32;
  logic [31:0] sum32;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int nrdy  = 0;

  typedef struct {
    logic [33:0] res;
    int          cyc;
    int          nrdy;
  } exp_t;
  exp_t q8[$];
  exp_t q13[$];
  exp_t q32[$];

  ks_adder_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
    .in_a(a32[7:0]), .in_b(b32[7:0]), .in_cin(cin), .in_sub(sub),
    .out_valid(ov8), .out_ready(out_ready8), .out_sum(sum8),
    .out_cout(cout8), .out_ovf(ovf8), .busy(busy8)
  );

  ks_adder_pipe #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir13),
    .in_a(a32[12:0]), .in_b(b32[12:0]), .in_cin(cin), .in_sub(sub),
    .out_valid(ov13), .out_ready(1'b1), .out_sum(sum13),
    .out_cout(cout13), .out_ovf(ovf13), .busy(busy13)
  );

  ks_adder_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
    .in_a(a32), .in_b(b32), .in_cin(cin), .in_sub(sub),
    .out_valid(ov32), .out_ready(1'b1), .out_sum(sum32),
    .out_cout(cout32), .out_ovf(ovf32), .busy(busy32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Result as {ovf, cout, sum} from integer arithmetic on unsigned and signed views.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic sb_op);
    longint m, half, ua, ub, sa, sb, u, s, c;
    logic   co, ov;
    m    = longint'(1) << w;
    half = m / 2;
    c    = ci ? 1 : 0;
    ua   = longint'({32'd0, a}) & (m - 1);
    ub   = longint'({32'd0, b}) & (m - 1);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (sb_op) begin
      u  = ua - ub - c;
      s  = sa - sb - c;
      co = (u >= 0);
    end else begin
      u  = ua + ub + c;
      s  = sa + sb + c;
      co = (u >= m);
    end
    ov = (s >= half) || (s < -half);
    return {ov, co, 32'(u & (m - 1))};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready8 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready8 = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q8.delete();
      q13.delete();
      q32.delete();
    end else begin
      if (!out_ready8) nrdy++;
      if (ov8) begin
        if (q8.size() == 0) check("w8_spurious", 64'(ov8), 64'd0);
        else begin
          check("w8_result", 64'({ovf8, cout8, 24'd0, sum8}), 64'(q8[0].res));
          if (out_ready8) begin
            if (q8[0].nrdy == nrdy) check("w8_latency", 64'(cyc - q8[0].cyc), 64'd5);
            void'(q8.pop_front());
          end
        end
      end
      if (ov13) begin
        if (q13.size() == 0) check("w13_spurious", 64'(ov13), 64'd0);
        else begin
          check("w13_result", 64'({ovf13, cout13, 19'd0, sum13}), 64'(q13[0].res));
          check("w13_latency", 64'(cyc - q13[0].cyc), 64'd6);
          void'(q13.pop_front());
        end
      end
      if (ov32) begin
        if (q32.size() == 0) check("w32_spurious", 64'(ov32), 64'd0);
        else begin
          check("w32_result", 64'({ovf32, cout32, sum32}), 64'(q32[0].res));
          check("w32_latency", 64'(cyc - q32[0].cyc), 64'd7);
          void'(q32.pop_front());
        end
      end
      if (in_valid && ir8)  q8.push_back('{exp_cur, cyc, nrdy});
      if (in_valid && ir13) q13.push_back('{ref_op(13, a32, b32, cin, sub), cyc, nrdy});
      if (in_valid && ir32) q32.push_back('{ref_op(32, a32, b32, cin, sub), cyc, nrdy});
    end
  end

  task automatic wait_accept();
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = ir8;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                         input logic [9:0] exp10);
    a32      = {24'd0, a};
    b32      = {24'd0, b};
    cin      = c;
    sub      = s;
    exp_cur  = {exp10[9:8], 24'd0, exp10[7:0]};
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic send_rand();
    a32      = $urandom;
    b32      = $urandom;
    cin      = 1'($urandom_range(0, 1));
    sub      = 1'($urandom_range(0, 1));
    exp_cur  = ref_op(8, a32, b32, cin, sub);
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; in_valid = 1'b0; a32 = 32'd0; b32 = 32'd0;
    cin = 1'b0; sub = 1'b0; exp_cur = 34'd0; rdy_rand = 1'b0;
    #12;
    check("rst_out_valid", 64'(ov8),   64'd0);
    check("rst_busy",      64'(busy8), 64'd0);
    check("rst_in_ready",  64'(ir8),   64'd1);
    check("rst_out_sum",   64'(sum8),  64'd0);
    check("rst_out_cout",  64'(cout8), 64'd0);
    check("rst_out_ovf",   64'(ovf8),  64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Directed corner cases with literal expectations {ovf, cout, sum}.
    send_op(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    send_op(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
    send_op(8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00});
    send_op(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE});
    send_op(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
    send_op(8'h10, 8'h00, 1'b1, 1'b1, {1'b0, 1'b1, 8'h0F});
    send_op(8'h0F, 8'h01, 1'b1, 1'b0, {1'b0, 1'b0, 8'h11});
    idle(10);

    // Reset with entries in flight: everything dropped, nothing emerges afterwards.
    repeat (3) send_rand();
    in_valid = 1'b0;
    check("busy_inflight", 64'(busy8), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ov8),   64'd0);
    check("midrst_busy",      64'(busy8), 64'd0);
    check("midrst_in_ready",  64'(ir8),   64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(12);
    check("postrst_busy", 64'(busy8 | busy13 | busy32), 64'd0);

    // Back-to-back stream under random backpressure.
    rdy_rand = 1'b1;
    repeat (20) send_rand();
    idle(2);
    rdy_rand = 1'b0;
    idle(20);

    // Sustained throughput with out_ready held high.
    t0 = cyc;
    repeat (30) send_rand();
    check("throughput_cycles", 64'(cyc - t0), 64'd30);
    idle(10);

    // Long random run.
    rdy_rand = 1'b1;
    for (int i = 0; i < 13000; i++) begin
      a32      = $urandom;
      b32      = $urandom;
      cin      = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 9) < 8);
      exp_cur  = ref_op(8, a32, b32, cin, sub);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rdy_rand = 1'b0;
    for (int i = 0; i < 200 && (q8.size() + q13.size() + q32.size()) != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(q8.size() + q13.size() + q32.size()), 64'd0);
    idle(2);
    check("final_busy", 64'(busy8 | busy13 | busy32), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
